// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the riscv_debug core.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage so a
// pushed word becomes visible only after the clock edge that writes it.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

`ifndef SYNTHESIS
    a_no_overflow:  assert property (@(posedge clk) disable iff (reset)
                                     !(push && full && !pop && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
                                     !(pop && empty && !flush));
`endif

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: PC register, credit-limited in-order imem requests,
// response buffering with PC tagging, and redirect flush/discard handling.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [ILEN-1:0]   imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ILEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic [XLEN-1:0]   instr_pc_plus4
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW:0]     credit_used;

    logic            req_fire;
    logic            rsp_keep;
    logic            instr_pop;

    fetch_entry_t    buf_push_entry;
    fetch_entry_t    buf_head;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;

    logic [XLEN-1:0] pcq_head;
    logic            pcq_full;
    logic            pcq_empty;
    logic [CW-1:0]   pcq_count;
    logic            unused_flags;

    // Discarded responses still hold a credit until they return.
    assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = !reset && !redirect_valid
                            && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Only kept responses consume a PC-queue entry; the queue was already
    // flushed of the entries belonging to discarded requests.
    assign rsp_keep       = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign instr_pop      = instr_valid && instr_ready;

    assign buf_push_entry = '{pc: pcq_head, instr: imem_rsp_data};

    assign instr_valid    = !buf_empty;
    assign instr          = buf_head.instr;
    assign instr_pc       = buf_head.pc;
    assign instr_pc_plus4 = buf_head.pc + 32'd4;

    assign unused_flags   = ^{buf_full, pcq_full, pcq_empty, pcq_count};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc      <= word_align(redirect_pc);
                discard <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (buf_push_entry),
        .pop       (instr_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pcq (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

`ifndef SYNTHESIS
    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
                                     imem_rsp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Scoreboard bench for riscv_fetch: a memory model answers requests in order,
// expected {pc, word} pairs are queued at request time and compared at decode.
module tb_riscv_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    riscv_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    exp_t        sb[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due = 0;
    int          mem_lat = 1;
    logic [31:0] exp_pc = RESET_PC;

    logic        rand_req = 1'b0;
    logic        rand_instr = 1'b0;
    logic        rand_lat = 1'b0;
    logic        stall = 1'b0;
    logic        redir_pend = 1'b0;
    logic        redir_coincide = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    logic        after_redir = 1'b0;

    int          req_count = 0;
    int          pop_count = 0;
    int          cap_n = 2;
    logic [31:0] cap_pc [2];
    logic        req_cap_armed = 1'b0;
    logic [31:0] first_req_addr = 32'h0;
    logic        coinc_seen = 1'b0;
    logic        saw_wrap = 1'b0;
    logic [31:0] wrap_plus4 = 32'hFFFF_FFFF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ a ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, evaluate handshakes just after.
    task automatic step();
        int   lat;
        int   due;
        logic rsp_now;
        logic popped;
        exp_t e;
        @(negedge clk);
        cyc++;
        rsp_now = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_valid = rsp_now;
        if (rsp_now) imem_rsp_data = mem_word(mq_addr[0]);
        else         imem_rsp_data = 32'hDEAD_BEEF;
        imem_req_ready = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall)           instr_ready = 1'b0;
        else if (rand_instr) instr_ready = 1'($urandom_range(0, 1));
        else                 instr_ready = 1'b1;
        redirect_valid = redir_pend && (!redir_coincide || (instr_valid && instr_ready && rsp_now));
        redirect_pc    = redir_tgt;
        if (redirect_valid) redir_pend = 1'b0;
        #1;
        if (after_redir) begin
            check("valid_after_redirect", 32'(instr_valid), 32'd0);
            after_redir = 1'b0;
        end
        popped = instr_valid && instr_ready;
        if (popped) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.instr);
                check("instr_pc_plus4", instr_pc_plus4, e.pc + 32'd4);
            end
            pop_count++;
            if (cap_n < 2) begin
                cap_pc[cap_n] = instr_pc;
                cap_n++;
            end
            if (instr_pc == 32'hFFFF_FFFC) begin
                saw_wrap   = 1'b1;
                wrap_plus4 = instr_pc_plus4;
            end
        end
        if (rsp_now) begin
            mq_addr.delete(0);
            mq_due.delete(0);
        end
        if (redirect_valid) check("req_in_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
            lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mq_addr.push_back(exp_pc);
            mq_due.push_back(due);
            last_due = due;
            exp_pc   = exp_pc + 32'd4;
            req_count++;
            if (req_cap_armed) begin
                first_req_addr = imem_req_addr;
                req_cap_armed  = 1'b0;
            end
        end
        if (redirect_valid) begin
            if (popped && rsp_now) coinc_seen = 1'b1;
            sb.delete();
            exp_pc        = redir_tgt & ~32'h3;
            after_redir   = 1'b1;
            cap_n         = 0;
            req_cap_armed = 1'b1;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must settle before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redir_pend     = 1'b0;
        #1;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_pc_plus4", instr_pc_plus4, 32'd4);
        sb.delete();
        mq_addr.delete();
        mq_due.delete();
        exp_pc      = RESET_PC;
        last_due    = cyc;
        after_redir = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pop_before;

        // Streaming fetch with 1-cycle memory.
        do_reset();
        mem_lat = 1;
        pop_before = pop_count;
        repeat (20) step();
        check("t1_progress", 32'(pop_count - pop_before >= 6), 32'd1);

        // Decode stall: credits cap the requests at FIFO_DEPTH.
        do_reset();
        stall = 1'b1;
        req_count = 0;
        repeat (10) step();
        check("t2_req_count", 32'(req_count), 32'd2);
        check("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
        check("t2_instr_valid", 32'(instr_valid), 32'd1);
        stall = 1'b0;
        repeat (20) step();

        // Redirect with two responses in flight.
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 20 && mq_addr.size() != 2; i++) step();
        check("t3_in_flight", 32'(mq_addr.size()), 32'd2);
        redir_tgt  = 32'h0000_0100;
        redir_pend = 1'b1;
        step();
        for (int i = 0; i < 40 && cap_n < 2; i++) step();
        check("t3_delivered", 32'(cap_n), 32'd2);
        check("t3_first_pc", cap_pc[0], 32'h0000_0100);
        check("t3_second_pc", cap_pc[1], 32'h0000_0104);

        // Redirect coinciding with a response and a decode pop.
        mem_lat = 1;
        repeat (8) step();
        coinc_seen     = 1'b0;
        redir_coincide = 1'b1;
        redir_tgt      = 32'h0000_0203;
        redir_pend     = 1'b1;
        for (int i = 0; i < 50 && redir_pend; i++) step();
        redir_coincide = 1'b0;
        check("t4_coincide", 32'(coinc_seen), 32'd1);
        for (int i = 0; i < 20 && req_cap_armed; i++) step();
        check("t4_next_addr", first_req_addr, 32'h0000_0200);
        repeat (10) step();

        // PC wrap at the top of the address space.
        saw_wrap   = 1'b0;
        redir_tgt  = 32'hFFFF_FFF8;
        redir_pend = 1'b1;
        repeat (20) step();
        check("t5_saw_wrap", 32'(saw_wrap), 32'd1);
        check("t5_wrap_plus4", wrap_plus4, 32'h0000_0000);

        // Random backpressure, latency and redirects, then reset mid-burst.
        rand_req   = 1'b1;
        rand_instr = 1'b1;
        rand_lat   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!redir_pend && $urandom_range(0, 19) == 0) begin
                redir_tgt  = $urandom;
                redir_pend = 1'b1;
            end
            step();
        end
        rand_req   = 1'b0;
        rand_instr = 1'b0;
        rand_lat   = 1'b0;
        mem_lat    = 2;
        repeat (3) step();
        do_reset();
        pop_before = pop_count;
        repeat (20) step();
        check("t6_progress", 32'(pop_count > pop_before), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
